large_memory_mp: RTL and testbench
==================================

LARGE_MEMORY_MP -- requirements
Module: large_memory_mp

Interface
REQ-001 Parameter DEPTH_WORDS, default 655360: number of DATA_WIDTH words stored.
REQ-002 Parameter DATA_WIDTH, default 32: word width; multiple of 8.
REQ-003 Parameter READ_PORTS, default 2, range 1..4: number of independent read channels.
REQ-004 Parameter READ_LATENCY, default 2, range 1..4: posedges from read grant to completion.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-007 in_addr  input  32  write byte address; word index = in_addr>>2, bits [1:0] ignored.
REQ-008 in_data  input  DATA_WIDTH  write data.
REQ-009 in_strb  input  DATA_WIDTH/8  byte-lane write enables.
REQ-010 in_valid  input  1  write request, held by requester until in_ready.
REQ-011 in_ready  output  1  one-cycle write-completion pulse.
REQ-012 rd_addr  input  32*READ_PORTS  per-channel read byte address, channel i in bits [32i+31:32i].
REQ-013 rd_valid  input  READ_PORTS  per-channel read request, held until rd_ready.
REQ-014 rd_ready  output  READ_PORTS  per-channel one-cycle read-completion pulse.
REQ-015 rd_data  output  DATA_WIDTH*READ_PORTS  per-channel read data.
REQ-016 addr_error  output  1  sticky out-of-range flag.
REQ-017 err_src  output  3  source of first error: 0 = write, 1+i = read channel i.

Function
REQ-018 Write FSM SHALL have states IDLE, DONE; IDLE with in_valid=1 at posedge -> write lanes with in_strb=1, go DONE; DONE -> IDLE unconditionally, in_valid ignored.
REQ-019 in_ready SHALL be 1 exactly while write FSM is in DONE; a held in_valid completes writes every second cycle (ready 1,0,1,...).
REQ-020 Each read channel SHALL have states IDLE, WAIT, DONE; rd_ready[i]=1 only in DONE, for exactly one cycle; DONE -> IDLE ignoring rd_valid[i].
REQ-021 A single shared memory read port SHALL grant at most one IDLE channel with rd_valid=1 per posedge; granted channel -> WAIT.
REQ-022 Arbitration SHALL be round-robin: pointer=0 after reset, search from pointer upward with wrap, pointer := granted+1 mod READ_PORTS.
REQ-023 Granted request SHALL traverse a READ_LATENCY-stage pipeline carrying channel id, error bit, data; channel -> DONE at the READ_LATENCY-th posedge after grant.
REQ-024 Pipeline SHALL accept one grant per cycle; different channels may complete on consecutive cycles.
REQ-025 rd_data[i] SHALL update only on entry to DONE and hold until channel i's next completion.
REQ-026 Read granted same posedge as write to same word SHALL return post-write data (strobed bytes new, others old).
REQ-027 Address out of range (addr >= DEPTH_WORDS*4) SHALL be checked only on an accepted request; idle invalid addresses never flag.
REQ-028 Out-of-range write SHALL not modify memory yet complete normally (in_ready pulse).
REQ-029 Out-of-range read SHALL complete normally with rd_data[i]=0.
REQ-030 addr_error SHALL set on the posedge that accepts the first out-of-range request, stay 1 until reset; err_src latched then, unchanged by later errors.
REQ-031 Simultaneous first errors from write and read SHALL record err_src=0.

Reset
REQ-032 reset=0 SHALL immediately force: in_ready=0, rd_ready=0, rd_data=0, addr_error=0, err_src=0, all FSMs IDLE, pipeline empty, pointer=0.
REQ-033 Reset mid-operation SHALL drop in-flight reads without any rd_ready pulse; memory contents are unspecified afterwards.
REQ-034 First request sampling SHALL occur at the first posedge after reset rises.

Verification
REQ-035 Defaults; write 36<-efefefef, 40<-c3c3c3c3, 32<-35353535 with in_valid held across last two -> in_ready 1, 0, 1 pattern; ch0 reads return values with rd_ready high 3rd cycle after request.
REQ-036 Write 40 strb=4'b0011 data 0000aaaa over c3c3c3c3 -> read 40 returns c3c3aaaa.
REQ-037 Both channels request simultaneously after reset -> ch0 completes cycle 3, ch1 cycle 4; repeated contention alternates order.
REQ-038 Write and ch1 read of word 10 granted same posedge -> ch1 returns new data.
REQ-039 Idle in_addr=DEPTH_WORDS*4 -> addr_error=0; write DEPTH_WORDS*4-1 -> error 0; write DEPTH_WORDS*4 -> in_ready=1, addr_error=1, err_src=0; ch1 read out of range after reset -> rd_data=0, err_src=2.
REQ-040 Assert reset while ch0 read in WAIT -> all outputs 0 immediately, no rd_ready pulse after release.

Source files
------------

// File: rtl/large_memory_mp.sv
// Byte-strobed word memory with one write channel and READ_PORTS round-robin
// arbitrated read channels sharing a single READ_LATENCY-deep read pipeline.
module large_memory_mp_ch #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gnt_i,
  input  logic                  done_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  idle_o,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  typedef enum logic [1:0] {CH_IDLE, CH_WAIT, CH_DONE} ch_st_t;
  ch_st_t st_q, st_d;
  logic [DATA_WIDTH-1:0] data_q;

  always_comb begin
    st_d = st_q;
    case (st_q)
      CH_IDLE: if (gnt_i)  st_d = CH_WAIT;
      CH_WAIT: if (done_i) st_d = CH_DONE;
      CH_DONE: st_d = CH_IDLE;
      default: st_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= CH_IDLE;
      data_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == CH_WAIT && done_i) data_q <= data_i;
    end
  end

  assign idle_o  = (st_q == CH_IDLE);
  assign ready_o = (st_q == CH_DONE);
  assign data_o  = data_q;
endmodule

module large_memory_mp #(
  parameter int DEPTH_WORDS  = 655360,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_PORTS   = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [31:0]                      in_addr,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [DATA_WIDTH/8-1:0]          in_strb,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [32*READ_PORTS-1:0]         rd_addr,
  input  logic [READ_PORTS-1:0]            rd_valid,
  output logic [READ_PORTS-1:0]            rd_ready,
  output logic [DATA_WIDTH*READ_PORTS-1:0] rd_data,
  output logic                             addr_error,
  output logic [2:0]                       err_src
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CHW = (READ_PORTS > 1) ? $clog2(READ_PORTS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic {W_IDLE, W_DONE} wr_st_t;
  typedef struct packed {
    logic [CHW-1:0]        ch;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rd_ent_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  wr_st_t                wr_st_q, wr_st_d;
  logic                  wr_fire, wr_oor;
  logic [AW-1:0]         wr_idx;
  logic [CHW-1:0]        ptr_q, gnt_ch;
  logic                  gnt_vld, gnt_oor;
  logic [31:0]           gnt_addr;
  logic [AW-1:0]         gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;
  int                    idx;
  logic [READ_PORTS-1:0] ch_idle;
  rd_ent_t               pipe_q [1:READ_LATENCY];
  logic [READ_LATENCY:1] vld_pipe_q;
  logic                  done_vld;
  logic [CHW-1:0]        done_ch;
  logic [DATA_WIDTH-1:0] done_data;
  logic                  err_q;
  logic [2:0]            err_src_q;

  always_comb begin
    wr_st_d = wr_st_q;
    wr_fire = 1'b0;
    case (wr_st_q)
      W_IDLE: if (in_valid) begin
        wr_fire = 1'b1;
        wr_st_d = W_DONE;
      end
      default: wr_st_d = W_IDLE;
    endcase
  end

  assign wr_oor   = {1'b0, in_addr} >= LIMIT;
  assign wr_idx   = in_addr[AW+1:2];
  assign in_ready = (wr_st_q == W_DONE);

  // Memory itself is not reset; gating on reset keeps writes out while held.
  always_ff @(posedge clk) begin
    if (reset && wr_fire && !wr_oor)
      for (int b = 0; b < NB; b++)
        if (in_strb[b]) mem[wr_idx][8*b +: 8] <= in_data[8*b +: 8];
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    idx     = 0;
    for (int k = 0; k < READ_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % READ_PORTS;
      if (!gnt_vld && ch_idle[idx] && rd_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CHW'(idx);
      end
    end
  end

  assign gnt_addr = rd_addr[32*gnt_ch +: 32];
  assign gnt_oor  = {1'b0, gnt_addr} >= LIMIT;
  assign gnt_idx  = gnt_addr[AW+1:2];

  // Same-edge write to the granted word is forwarded so the read sees post-write data.
  always_comb begin
    gnt_data = mem[gnt_idx];
    if (wr_fire && !wr_oor && wr_idx == gnt_idx)
      for (int b = 0; b < NB; b++)
        if (in_strb[b]) gnt_data[8*b +: 8] = in_data[8*b +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      for (int k = 1; k <= READ_LATENCY; k++) pipe_q[k] <= '0;
    end else begin
      vld_pipe_q[1] <= gnt_vld;
      pipe_q[1]     <= '{ch: gnt_ch, err: gnt_oor, data: gnt_data};
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        pipe_q[k]     <= pipe_q[k-1];
      end
    end
  end

  assign done_vld  = vld_pipe_q[READ_LATENCY];
  assign done_ch   = pipe_q[READ_LATENCY].ch;
  assign done_data = pipe_q[READ_LATENCY].err ? '0 : pipe_q[READ_LATENCY].data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_st_q   <= W_IDLE;
      ptr_q     <= '0;
      err_q     <= 1'b0;
      err_src_q <= '0;
    end else begin
      wr_st_q <= wr_st_d;
      if (gnt_vld) ptr_q <= (gnt_ch == CHW'(READ_PORTS-1)) ? '0 : gnt_ch + 1'b1;
      if (!err_q) begin
        if (wr_fire && wr_oor) begin
          err_q     <= 1'b1;
          err_src_q <= 3'd0;
        end else if (gnt_vld && gnt_oor) begin
          err_q     <= 1'b1;
          err_src_q <= 3'(gnt_ch) + 3'd1;
        end
      end
    end
  end

  assign addr_error = err_q;
  assign err_src    = err_src_q;

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_ch
    large_memory_mp_ch #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .gnt_i  (gnt_vld && gnt_ch == CHW'(i)),
      .done_i (done_vld && done_ch == CHW'(i)),
      .data_i (done_data),
      .idle_o (ch_idle[i]),
      .ready_o(rd_ready[i]),
      .data_o (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_large_memory_mp.sv
// Directed self-checking bench for large_memory_mp (2 read channels, latency 2).
module tb_large_memory_mp;
  localparam logic [31:0] LIMIT = 32'd2621440;

  logic        clk, reset;
  logic [31:0] in_addr, in_data;
  logic [3:0]  in_strb;
  logic        in_valid, in_ready;
  logic [63:0] rd_addr;
  logic [1:0]  rd_valid, rd_ready;
  logic [63:0] rd_data;
  logic        addr_error;
  logic [2:0]  err_src;

  int n_chk = 0;
  int n_err = 0;

  large_memory_mp dut (
    .clk(clk), .reset(reset), .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
    .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .addr_error(addr_error), .err_src(err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0; in_valid = 1'b0; rd_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    in_addr = a; in_data = d; in_strb = s; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("wr_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_read(input int ch, input logic [31:0] a, output logic [31:0] d, output int lat);
    lat = 0; d = '0;
    rd_addr[32*ch +: 32] = a; rd_valid[ch] = 1'b1;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (rd_ready[ch]) begin lat = n; d = rd_data[32*ch +: 32]; end
    end
    rd_valid[ch] = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic contend(input int e0, input int e1);
    int l0, l1;
    l0 = 0; l1 = 0;
    rd_addr = {32'd40, 32'd36}; rd_valid = 2'b11;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); @(negedge clk);
      if (rd_ready[0] && l0 == 0) begin l0 = n; rd_valid[0] = 1'b0; end
      if (rd_ready[1] && l1 == 0) begin l1 = n; rd_valid[1] = 1'b0; end
    end
    rd_valid = '0;
    chk("arb_lat_ch0", 64'(l0), 64'(e0));
    chk("arb_lat_ch1", 64'(l1), 64'(e1));
  endtask

  initial begin
    logic [31:0] d, d1;
    int lat, l1, saw;
    reset = 1'b0; in_addr = '0; in_data = '0; in_strb = '0; in_valid = 1'b0;
    rd_addr = '0; rd_valid = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addr_error", addr_error, 0);
    chk("rst_err_src", err_src, 0);
    reset = 1'b1;

    // Single write, then two writes with in_valid held: ready 1,0,1
    do_write(32'd36, 32'hefefefef, 4'hf);
    in_addr = 32'd40; in_data = 32'hc3c3c3c3; in_strb = 4'hf; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("held_rdy0", in_ready, 1);
    in_addr = 32'd32; in_data = 32'h35353535;
    @(posedge clk); @(negedge clk);
    chk("held_rdy1", in_ready, 0);
    @(posedge clk); @(negedge clk);
    chk("held_rdy2", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);

    do_read(0, 32'd36, d, lat);
    chk("rd36_data", d, 32'hefefefef); chk("rd36_lat", 64'(lat), 3);
    do_read(0, 32'd42, d, lat);
    chk("rd40_data", d, 32'hc3c3c3c3); chk("rd40_lat", 64'(lat), 3);
    do_read(0, 32'd32, d, lat);
    chk("rd32_data", d, 32'h35353535);

    // Partial strobe merge
    do_write(32'd40, 32'h0000aaaa, 4'b0011);
    do_read(0, 32'd40, d, lat);
    chk("strb_merge", d, 32'hc3c3aaaa);

    // Arbitration: pointer 0 after reset, then pointer 1 after a lone ch0 grant
    apply_reset();
    contend(3, 4);
    do_read(0, 32'd36, d, lat);
    contend(4, 3);

    // Write and ch1 read of word 10 on the same edge
    do_write(32'd40, 32'h11111111, 4'hf);
    in_addr = 32'd40; in_data = 32'h0000bbbb; in_strb = 4'b0011; in_valid = 1'b1;
    rd_addr[63:32] = 32'd40; rd_valid[1] = 1'b1;
    l1 = 0; d1 = '0;
    for (int n = 1; n <= 10 && l1 == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) begin chk("fwd_wr_ready", in_ready, 1); in_valid = 1'b0; end
      if (rd_ready[1]) begin l1 = n; d1 = rd_data[63:32]; end
    end
    rd_valid[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("fwd_data", d1, 32'h1111bbbb);
    chk("fwd_lat", 64'(l1), 3);

    // Address range boundary
    apply_reset();
    in_addr = LIMIT; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_oor_noerr", addr_error, 0);
    do_write(LIMIT - 32'd1, 32'h12345678, 4'hf);
    chk("wr_last_noerr", addr_error, 0);
    do_write(LIMIT, 32'hdeadbeef, 4'hf);
    chk("wr_oor_err", addr_error, 1);
    chk("wr_oor_src", err_src, 0);

    apply_reset();
    do_write(32'd44, 32'h5a5a5a5a, 4'hf);
    do_read(1, 32'd44, d, lat);
    chk("ch1_rd44", d, 32'h5a5a5a5a);
    chk("ch1_noerr", addr_error, 0);
    do_read(1, LIMIT, d, lat);
    chk("ch1_oor_data", d, 0);
    chk("ch1_oor_lat", 64'(lat), 3);
    chk("ch1_oor_err", addr_error, 1);
    chk("ch1_oor_src", err_src, 2);
    do_write(LIMIT, 32'h0, 4'hf);
    chk("err_src_sticky", err_src, 2);

    // Reset with ch0 read in flight
    do_write(32'd36, 32'hefefefef, 4'hf);
    do_read(0, 32'd36, d, lat);
    chk("pre_rst_data", rd_data[31:0], 32'hefefefef);
    rd_addr[31:0] = 32'd36; rd_valid[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_rd_ready", rd_ready, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_err", addr_error, 0);
    chk("mid_rst_src", err_src, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rd_valid = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    saw = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (rd_ready != 0) saw++;
    end
    chk("no_ready_after_rst", 64'(saw), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
